// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input peripheral: register offsets and bus word type.
package gpio_pkg;

    localparam int GPIO_BUS_W = 32;

    typedef logic [GPIO_BUS_W-1:0] gpio_word_t;

    localparam logic [7:0] GPIO_DATA_OFS  = 8'h00;
    localparam logic [7:0] GPIO_EDGE_OFS  = 8'h04;
    localparam logic [7:0] GPIO_MASK_OFS  = 8'h08;
    localparam logic [7:0] GPIO_FALL_OFS  = 8'h0C;
    localparam logic [7:0] GPIO_FMASK_OFS = 8'h10;

    // Byte offsets are word aligned; the two lowest address bits never select a register.
    function automatic logic [7:0] gpio_word_ofs(input logic [7:0] byte_ofs);
        return byte_ofs & 8'hFC;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input pin: two-flop synchronizer followed by a tick-sampled debounce counter.
module gpio_debounce_bit #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic tick,
    output logic deb,
    output logic deb_next
);

    localparam int CNT_W = $clog2(DEB_SAMPLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    assign differ   = (sync_p1 != deb);
    assign accept   = tick & differ & (cnt == CNT_W'(DEB_SAMPLES - 1));
    assign deb_next = accept ? sync_p1 : deb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            deb     <= 1'b0;
            cnt     <= '0;
        end else begin
            // stage 0 -> 1: metastability filter
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            deb     <= deb_next;
            // any equal sample restarts the run of differing samples
            if (tick) begin
                if (!differ || accept)
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_in_port.sv
// Memory-mapped GPIO input port: debounced pins, sticky rising-edge flags, maskable irq.
// Optional falling-edge flags and mask are built when GPIO_IN_FALL_EDGE_EN is defined.
module gpio_in_port
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 9,
    parameter int BIT_WIDTH   = 32,
    parameter int ADDR_W      = 4,
    parameter int DEB_TICKS   = 1000,
    parameter int DEB_SAMPLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO_WIDTH-1:0] gpio_pins,
    input  logic                  sel,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [BIT_WIDTH-1:0]  wr_data,
    output logic [BIT_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  irq
);

    localparam int PS_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

    logic [PS_W-1:0]       ps_cnt;
    logic                  tick;
    logic [GPIO_WIDTH-1:0] deb;
    logic [GPIO_WIDTH-1:0] deb_next;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] edge_flags;
    logic [GPIO_WIDTH-1:0] mask_q;
    logic [GPIO_WIDTH-1:0] wr_bits;
    logic [7:0]            ofs;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  fall_irq;
    logic [BIT_WIDTH-1:0]  rd_mux;
    logic                  unused_bits;

    assign tick = (ps_cnt == PS_W'(DEB_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ps_cnt <= '0;
        else
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_deb
        gpio_debounce_bit #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .pin      (gpio_pins[i]),
            .tick     (tick),
            .deb      (deb[i]),
            .deb_next (deb_next[i])
        );
    end

    assign rise        = deb_next & ~deb;
    assign ofs         = gpio_word_ofs(8'(addr));
    assign wr_fire     = sel & wr_en;
    assign rd_fire     = sel & rd_en;
    assign wr_bits     = wr_data[GPIO_WIDTH-1:0];
    assign unused_bits = ^wr_data[BIT_WIDTH-1:GPIO_WIDTH];

    // A new edge in the same cycle as its W1C keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_flags <= '0;
            mask_q     <= '0;
        end else begin
            edge_flags <= (edge_flags & ~((wr_fire && ofs == GPIO_EDGE_OFS) ? wr_bits : '0)) | rise;
            if (wr_fire && ofs == GPIO_MASK_OFS)
                mask_q <= wr_bits;
        end
    end

`ifdef GPIO_IN_FALL_EDGE_EN
    logic [GPIO_WIDTH-1:0] fall_flags;
    logic [GPIO_WIDTH-1:0] fmask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_flags <= '0;
            fmask_q    <= '0;
        end else begin
            fall_flags <= (fall_flags & ~((wr_fire && ofs == GPIO_FALL_OFS) ? wr_bits : '0))
                        | (~deb_next & deb);
            if (wr_fire && ofs == GPIO_FMASK_OFS)
                fmask_q <= wr_bits;
        end
    end

    assign fall_irq = |(fall_flags & fmask_q);
`else
    assign fall_irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (ofs)
            GPIO_DATA_OFS:  rd_mux = BIT_WIDTH'(deb);
            GPIO_EDGE_OFS:  rd_mux = BIT_WIDTH'(edge_flags);
            GPIO_MASK_OFS:  rd_mux = BIT_WIDTH'(mask_q);
`ifdef GPIO_IN_FALL_EDGE_EN
            GPIO_FALL_OFS:  rd_mux = BIT_WIDTH'(fall_flags);
            GPIO_FMASK_OFS: rd_mux = BIT_WIDTH'(fmask_q);
`endif
            default:        rd_mux = '0;
        endcase
    end

    // Read data comes from pre-write register state, so a combined read+write returns the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire)
                rd_data <= rd_mux;
            irq <= (|(edge_flags & mask_q)) | fall_irq;
        end
    end

endmodule

// File: tb/tb_gpio_in_port.sv
// Self-checking bench for gpio_in_port with fast debounce (4-cycle ticks, 3 samples).
module tb_gpio_in_port;
    import gpio_pkg::*;

    localparam int GW     = 9;
    localparam int BW     = 32;
    localparam int AW     = 5;
    localparam int DT     = 4;
    localparam int DS     = 3;
    localparam int SETTLE = 24;

    localparam logic [AW-1:0] A_DATA  = 5'h00;
    localparam logic [AW-1:0] A_EDGE  = 5'h04;
    localparam logic [AW-1:0] A_MASK  = 5'h08;
    localparam logic [AW-1:0] A_FALL  = 5'h0C;
    localparam logic [AW-1:0] A_FMASK = 5'h10;

    logic          clk;
    logic          rst;
    logic [GW-1:0] gpio_pins;
    logic          sel;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] addr;
    gpio_word_t    wr_data;
    gpio_word_t    rd_data;
    logic          rd_valid;
    logic          irq;

    int checks   = 0;
    int failures = 0;
    int edge_cnt;

    logic [GW-1:0] cur;
    logic [GW-1:0] edge_m;
    logic [GW-1:0] mask_m;

    gpio_in_port #(
        .GPIO_WIDTH  (GW),
        .BIT_WIDTH   (BW),
        .ADDR_W      (AW),
        .DEB_TICKS   (DT),
        .DEB_SAMPLES (DS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_pins (gpio_pins),
        .sel       (sel),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; the sample tick lands on every DT-th edge.
    always @(posedge clk or posedge rst) begin
        if (rst)
            edge_cnt <= 0;
        else
            edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A level applied right after edge e0 reaches the synchronizer output two edges
    // later and is accepted on the DS-th tick that sees it.
    function automatic int accept_edge(input int e0);
        int e;
        e = e0 + 3;
        while (e % DT != 0) e++;
        return e + (DS - 1) * DT;
    endfunction

    task automatic bus_write(input logic [AW-1:0] a, input gpio_word_t d);
        sel = 1'b1; wr_en = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        sel = 1'b0; wr_en = 1'b0; wr_data = '0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output gpio_word_t d, output logic v);
        sel = 1'b1; rd_en = 1'b1; addr = a;
        @(posedge clk);
        #1;
        d = rd_data;
        v = rd_valid;
        sel = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset;
        gpio_word_t d;
        logic v;
        step(3);
        checks++;
        if ({rd_data, rd_valid, irq} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rd_data=%h rd_valid=%b irq=%b want 0", rd_data, rd_valid, irq);
        end
        rst = 1'b0;
        gpio_pins = 9'h1FF;
        bus_write(A_MASK, 32'h1FF);
        step(SETTLE);
        bus_read(A_MASK, d, v);
        checks++;
        if (d !== 32'h1FF) begin
            failures++;
            $display("FAIL pre_reset_mask got %h want %h", d, 32'h1FF);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq got %b want 1", irq);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({rd_data, rd_valid, irq} !== '0) begin
            failures++;
            $display("FAIL async_reset got rd_data=%h rd_valid=%b irq=%b want 0", rd_data, rd_valid, irq);
        end
        step(2);
        rst = 1'b0;
        bus_read(A_DATA, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_data_early got %h want 0", d);
        end
        bus_read(A_MASK, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_mask got %h want 0", d);
        end
        wait_until_edge(accept_edge(0) - 1);
        bus_read(A_DATA, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL data_before_window got %h want 0", d);
        end
        bus_read(A_DATA, d, v);
        checks++;
        if (d !== 32'h1FF) begin
            failures++;
            $display("FAIL data_after_window got %h want %h", d, 32'h1FF);
        end
        bus_read(A_EDGE, d, v);
        checks++;
        if (d !== 32'h1FF) begin
            failures++;
            $display("FAIL post_reset_edge got %h want %h", d, 32'h1FF);
        end
        cur = 9'h1FF;
    endtask

    task automatic test_glitch;
        gpio_word_t d;
        logic v;
        gpio_pins = '0;
        cur = '0;
        step(SETTLE);
        bus_write(A_EDGE, 32'h1FF);
        bus_write(A_MASK, 32'h1FF);
        gpio_pins[0] = 1'b1;
        step(2 * DT);
        gpio_pins[0] = 1'b0;
        step(SETTLE);
        bus_read(A_DATA, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL glitch_data got %h want 0", d);
        end
        bus_read(A_EDGE, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL glitch_edge got %h want 0", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL glitch_irq got %b want 0", irq);
        end
    endtask

    task automatic test_edge_irq;
        gpio_word_t d;
        logic v;
        int ea;
        bus_write(A_MASK, 32'h004);
        ea = accept_edge(edge_cnt);
        gpio_pins[2] = 1'b1;
        wait_until_edge(ea);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_latency_early got %b want 0", irq);
        end
        step(1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_latency got %b want 1", irq);
        end
        bus_read(A_DATA, d, v);
        checks++;
        if (d !== 32'h004) begin
            failures++;
            $display("FAIL edge_test_data got %h want %h", d, 32'h004);
        end
        bus_read(A_EDGE, d, v);
        checks++;
        if (d !== 32'h004) begin
            failures++;
            $display("FAIL edge_test_edge got %h want %h", d, 32'h004);
        end
        bus_write(A_EDGE, 32'h004);
        bus_read(A_EDGE, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL edge_w1c got %h want 0", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_after_w1c got %b want 0", irq);
        end
        cur = 9'h004;
    endtask

    task automatic test_w1c_race;
        gpio_word_t d;
        logic v;
        int ea;
        ea = accept_edge(edge_cnt);
        gpio_pins[1] = 1'b1;
        wait_until_edge(ea - 1);
        bus_write(A_EDGE, 32'h002);
        bus_read(A_EDGE, d, v);
        checks++;
        if (d !== 32'h002) begin
            failures++;
            $display("FAIL w1c_race got %h want %h", d, 32'h002);
        end
        bus_write(A_EDGE, 32'h002);
        bus_read(A_EDGE, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL w1c_after_race got %h want 0", d);
        end
        cur = 9'h006;
    endtask

    task automatic test_bus;
        gpio_word_t d;
        logic v;
        bus_write(A_MASK, 32'hFFFF_FFFF);
        bus_read(A_MASK, d, v);
        checks++;
        if (d !== 32'h0000_01FF || v !== 1'b1) begin
            failures++;
            $display("FAIL mask_readback got %h valid=%b want 000001ff valid=1", d, v);
        end
        step(1);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0000_01FF) begin
            failures++;
            $display("FAIL rd_valid_pulse got valid=%b data=%h want valid=0 data=000001ff", rd_valid, rd_data);
        end
        bus_read(5'h09, d, v);
        checks++;
        if (d !== 32'h1FF) begin
            failures++;
            $display("FAIL unaligned_mask got %h want %h", d, 32'h1FF);
        end
        sel = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr = A_MASK; wr_data = 32'h0;
        @(posedge clk);
        #1;
        sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if (rd_data !== 32'h1FF) begin
            failures++;
            $display("FAIL rw_collision_read got %h want %h", rd_data, 32'h1FF);
        end
        bus_read(A_MASK, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rw_collision_write got %h want 0", d);
        end
        bus_write(A_DATA, 32'hFFFF_FFFF);
        bus_read(A_DATA, d, v);
        checks++;
        if (d !== 32'(cur)) begin
            failures++;
            $display("FAIL data_write_ignored got %h want %h", d, 32'(cur));
        end
        bus_read(5'h1C, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read got %h want 0", d);
        end
        mask_m = '0;
    endtask

    task automatic test_random;
        gpio_word_t d;
        logic v;
        logic [GW-1:0] newpat;
        logic [GW-1:0] gm;
        logic [GW-1:0] clr;
        bus_write(A_EDGE, 32'h1FF);
        edge_m = '0;
        for (int it = 0; it < 8; it++) begin
            newpat = GW'($urandom);
            gpio_pins = newpat;
            edge_m = edge_m | (newpat & ~cur);
            cur = newpat;
            step(SETTLE);
            gm = GW'($urandom) | 9'h001;
            gpio_pins = cur ^ gm;
            step($urandom_range(1, 2 * DT - 1));
            gpio_pins = cur;
            step(SETTLE);
            clr = GW'($urandom);
            bus_write(A_EDGE, 32'(clr));
            edge_m = edge_m & ~clr;
            mask_m = GW'($urandom);
            bus_write(A_MASK, 32'(mask_m));
            bus_read(A_DATA, d, v);
            checks++;
            if (d !== 32'(cur)) begin
                failures++;
                $display("FAIL rand_data[%0d] got %h want %h", it, d, 32'(cur));
            end
            bus_read(A_EDGE, d, v);
            checks++;
            if (d !== 32'(edge_m)) begin
                failures++;
                $display("FAIL rand_edge[%0d] got %h want %h", it, d, 32'(edge_m));
            end
            checks++;
            if (irq !== |(edge_m & mask_m)) begin
                failures++;
                $display("FAIL rand_irq[%0d] got %b want %b", it, irq, |(edge_m & mask_m));
            end
        end
    endtask

    task automatic test_optional;
        gpio_word_t d;
        logic v;
`ifdef GPIO_IN_FALL_EDGE_EN
        gpio_pins = '0;
        step(SETTLE);
        bus_write(A_EDGE, 32'h1FF);
        bus_write(A_FALL, 32'h1FF);
        bus_write(A_MASK, 32'h0);
        bus_write(A_FMASK, 32'h001);
        gpio_pins[0] = 1'b1;
        step(SETTLE);
        gpio_pins[0] = 1'b0;
        step(SETTLE);
        bus_read(A_FALL, d, v);
        checks++;
        if (d !== 32'h001) begin
            failures++;
            $display("FAIL fall_flag got %h want %h", d, 32'h001);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL fall_irq got %b want 1", irq);
        end
`else
        bus_write(A_FALL, 32'hFFFF_FFFF);
        bus_write(A_FMASK, 32'hFFFF_FFFF);
        bus_read(A_FALL, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reserved_0c got %h want 0", d);
        end
        bus_read(A_FMASK, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reserved_10 got %h want 0", d);
        end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        gpio_pins = '0;
        sel       = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        addr      = '0;
        wr_data   = '0;
        cur       = '0;
        edge_m    = '0;
        mask_m    = '0;
        test_reset();
        test_glitch();
        test_edge_irq();
        test_w1c_race();
        test_bus();
        test_random();
        test_optional();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
